// File: rtl/hilo_div_unit.sv
// ============================================================================
//  Module      : hilo_div_unit
//  Description : Architectural HI/LO registers plus a 32-cycle restoring
//                divider (DIV/DIVU) with stall handshake to execute.
//                Optional macro HILO_BYPASS_EN makes HI/LO write-through.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    input  logic        div_start_i,
    input  logic        div_signed_i,
    input  logic        div_annul_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [63:0] div_result_o,
    output logic        div_ready_o,
    output logic        stallreq_o
);

    localparam logic [1:0] c_FREE     = 2'd0;
    localparam logic [1:0] c_DIV_ZERO = 2'd1;
    localparam logic [1:0] c_DIV_ON   = 2'd2;
    localparam logic [1:0] c_DIV_END  = 2'd3;
    localparam logic [5:0] c_LAST_CNT = 6'(DIV_CYCLES - 1);

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_pr;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;
    logic        r_ready;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [31:0] w_dvd_abs;
    logic [31:0] w_dvs_abs;
    logic [64:0] w_shift;
    logic [32:0] w_diff;
    logic [63:0] w_next_pr;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // ------------------------------------------------------------------
    // HI/LO storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (we_i) begin
            r_hi <= hi_i;
            r_lo <= lo_i;
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi_o = we_i ? hi_i : r_hi;
    assign lo_o = we_i ? lo_i : r_lo;
`else
    assign hi_o = r_hi;
    assign lo_o = r_lo;
`endif

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_dvd_neg = div_signed_i & dividend_i[31];
        w_dvs_neg = div_signed_i & divisor_i[31];
        w_dvd_abs = w_dvd_neg ? (32'd0 - dividend_i) : dividend_i;
        w_dvs_abs = w_dvs_neg ? (32'd0 - divisor_i) : divisor_i;

        // The shifted remainder can reach 33 bits, so the trial subtract
        // uses bit 64 as well; a committed difference always fits in 32.
        w_shift   = {r_pr, 1'b0};
        w_diff    = w_shift[64:32] - {1'b0, r_divisor};
        w_next_pr = w_diff[32] ? w_shift[63:0]
                               : {w_diff[31:0], w_shift[31:1], 1'b1};

        w_quot_fix = r_neg_q ? (32'd0 - w_next_pr[31:0])  : w_next_pr[31:0];
        w_rem_fix  = r_neg_r ? (32'd0 - w_next_pr[63:32]) : w_next_pr[63:32];
    end

    // ------------------------------------------------------------------
    // Divider control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_FREE;
            r_cnt     <= 6'd0;
            r_pr      <= 64'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                c_FREE: begin
                    if (div_start_i && !div_annul_i) begin
                        if (divisor_i == 32'd0) begin
                            r_state <= c_DIV_ZERO;
                        end else begin
                            r_state   <= c_DIV_ON;
                            r_cnt     <= 6'd0;
                            r_pr      <= {32'd0, w_dvd_abs};
                            r_divisor <= w_dvs_abs;
                            r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r   <= w_dvd_neg;
                        end
                    end
                end
                c_DIV_ZERO: begin
                    r_state  <= c_DIV_END;
                    r_result <= 64'd0;
                    r_ready  <= 1'b1;
                end
                c_DIV_ON: begin
                    if (div_annul_i) begin
                        r_state <= c_FREE;
                        r_cnt   <= 6'd0;
                    end else if (r_cnt == c_LAST_CNT) begin
                        r_state  <= c_DIV_END;
                        r_cnt    <= 6'd0;
                        r_pr     <= w_next_pr;
                        r_result <= {w_rem_fix, w_quot_fix};
                        r_ready  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        r_pr  <= w_next_pr;
                    end
                end
                default: begin
                    if (!div_start_i) begin
                        r_state  <= c_FREE;
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign div_result_o = r_result;
    assign div_ready_o  = r_ready;
    assign stallreq_o   = div_start_i & ~r_ready & ~div_annul_i;

endmodule

`default_nettype wire
